// File: rtl/decode_sequencer.sv
// Registered instruction decoder: captures one instruction word, then walks the
// register-file port through read Rn / read Rm / write slots, one per cycle.
//
// state  | meaning
// IDLE   | waiting for an instruction
// RD_A   | read Rn (nsel=100)
// RD_B   | read Rm (nsel=001)
// WR     | write Rn (MOV imm) or Rd
// ILL    | unsupported encoding, one-cycle illegal pulse
module decode_sequencer #(
  parameter int DATA_W    = 16,
  parameter int BACK2BACK = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       instr,
  input  logic              stall,
  output logic [2:0]        nsel,
  output logic [2:0]        regnum,
  output logic              read_en,
  output logic              write_en,
  output logic              done,
  output logic              illegal,
  output logic [2:0]        opcode,
  output logic [1:0]        op,
  output logic [1:0]        aluop,
  output logic [1:0]        shift,
  output logic [DATA_W-1:0] sximm5,
  output logic [DATA_W-1:0] sximm8
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_A = 3'd1,
    S_RD_B = 3'd2,
    S_WR   = 3'd3,
    S_ILL  = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] ir;
  logic        is_cmp, is_movi, final_slot, accept;
  logic        read_raw, write_raw;

  // Entry slot chosen from opcode/op of the word being accepted.
  function automatic state_t first_slot(input logic [4:0] code);
    case (code)
      5'b110_10:                       first_slot = S_WR;
      5'b110_00, 5'b101_11:            first_slot = S_RD_B;
      5'b101_00, 5'b101_10, 5'b101_01: first_slot = S_RD_A;
      default:                         first_slot = S_ILL;
    endcase
  endfunction

  assign is_cmp     = (ir[15:11] == 5'b101_01);
  assign is_movi    = (ir[15:11] == 5'b110_10);
  assign final_slot = (state == S_WR) || ((state == S_RD_B) && is_cmp);
  assign in_ready   = (state == S_IDLE) || ((BACK2BACK != 0) && final_slot && !stall);
  assign accept     = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) ir <= instr;
    end
  end

  always_comb begin
    state_nxt = state;
    nsel      = 3'b000;
    regnum    = 3'd0;
    read_raw  = 1'b0;
    write_raw = 1'b0;
    case (state)
      S_RD_A: begin
        nsel     = 3'b100;
        regnum   = ir[10:8];
        read_raw = 1'b1;
        if (!stall) state_nxt = S_RD_B;
      end
      S_RD_B: begin
        nsel     = 3'b001;
        regnum   = ir[2:0];
        read_raw = 1'b1;
        if (!stall) state_nxt = is_cmp ? S_IDLE : S_WR;
      end
      S_WR: begin
        nsel      = is_movi ? 3'b100 : 3'b010;
        regnum    = is_movi ? ir[10:8] : ir[7:5];
        write_raw = 1'b1;
        if (!stall) state_nxt = S_IDLE;
      end
      S_ILL: begin
        if (!stall) state_nxt = S_IDLE;
      end
      default: state_nxt = state;
    endcase
    // A back-to-back accept overrides the return to IDLE.
    if (accept) state_nxt = first_slot(instr[15:11]);
  end

  // Enables and done are masked during reset so nothing reaches the register file.
  assign read_en  = read_raw && rst_n;
  assign write_en = write_raw && rst_n;
  assign done     = final_slot && !stall && rst_n;
  assign illegal  = (state == S_ILL);

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign aluop  = ir[12:11];
  assign shift  = ir[4:3];
  assign sximm5 = {{(DATA_W-5){ir[4]}}, ir[4:0]};
  assign sximm8 = {{(DATA_W-8){ir[7]}}, ir[7:0]};

endmodule

// File: tb/tb_decode_sequencer.sv
// Directed bench for decode_sequencer: a 16-bit back-to-back instance and a
// 32-bit bubble instance share stimulus and are checked against hand values.
module tb_decode_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] instr = 16'h0000;
  logic        stall = 1'b0;

  logic        a_in_ready, a_read_en, a_write_en, a_done, a_illegal;
  logic [2:0]  a_nsel, a_regnum, a_opcode;
  logic [1:0]  a_op, a_aluop, a_shift;
  logic [15:0] a_sximm5, a_sximm8;

  logic        b_in_ready, b_read_en, b_write_en, b_done, b_illegal;
  logic [2:0]  b_nsel, b_regnum, b_opcode;
  logic [1:0]  b_op, b_aluop, b_shift;
  logic [31:0] b_sximm5, b_sximm8;

  int total = 0;
  int bad = 0;

  // {in_ready, nsel, regnum, read_en, write_en, done, illegal}
  logic [10:0] a_ctl, b_ctl;
  logic [8:0]  a_fld, b_fld;
  assign a_ctl = {a_in_ready, a_nsel, a_regnum, a_read_en, a_write_en, a_done, a_illegal};
  assign b_ctl = {b_in_ready, b_nsel, b_regnum, b_read_en, b_write_en, b_done, b_illegal};
  assign a_fld = {a_opcode, a_op, a_aluop, a_shift};
  assign b_fld = {b_opcode, b_op, b_aluop, b_shift};

  localparam logic [10:0] IDLE_CTL = {1'b1, 3'b000, 3'd0, 4'b0000};

  decode_sequencer #(.DATA_W(16), .BACK2BACK(1)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .instr(instr), .stall(stall), .nsel(a_nsel), .regnum(a_regnum),
    .read_en(a_read_en), .write_en(a_write_en), .done(a_done), .illegal(a_illegal),
    .opcode(a_opcode), .op(a_op), .aluop(a_aluop), .shift(a_shift),
    .sximm5(a_sximm5), .sximm8(a_sximm8)
  );

  decode_sequencer #(.DATA_W(32), .BACK2BACK(0)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .instr(instr), .stall(stall), .nsel(b_nsel), .regnum(b_regnum),
    .read_en(b_read_en), .write_en(b_write_en), .done(b_done), .illegal(b_illegal),
    .opcode(b_opcode), .op(b_op), .aluop(b_aluop), .shift(b_shift),
    .sximm5(b_sximm5), .sximm8(b_sximm8)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a word for one edge; instr is scrambled afterwards.
  task automatic offer(input logic [15:0] w);
    in_valid = 1'b1;
    instr    = w;
    step();
    in_valid = 1'b0;
    instr    = 16'h5A5A;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (a_ctl !== IDLE_CTL) begin bad++; $display("FAIL reset_ctl16 got=%b exp=%b", a_ctl, IDLE_CTL); end
    total++; if (b_ctl !== IDLE_CTL) begin bad++; $display("FAIL reset_ctl32 got=%b exp=%b", b_ctl, IDLE_CTL); end
    total++; if (a_fld !== 9'd0) begin bad++; $display("FAIL reset_fields got=%h exp=0", a_fld); end
    total++; if ({a_sximm5, a_sximm8} !== 32'd0) begin bad++; $display("FAIL reset_imm16 got=%h exp=0", {a_sximm5, a_sximm8}); end
    total++; if ({b_sximm5, b_sximm8} !== 64'd0) begin bad++; $display("FAIL reset_imm32 got=%h exp=0", {b_sximm5, b_sximm8}); end
    step();
  endtask

  task automatic test_mov_imm();
    offer(16'hD3FB);
    @(negedge clk);
    total++; if (a_ctl !== {1'b1, 3'b100, 3'd3, 4'b0110}) begin bad++; $display("FAIL movi_wr16 got=%b exp=%b", a_ctl, {1'b1, 3'b100, 3'd3, 4'b0110}); end
    total++; if (b_ctl !== {1'b0, 3'b100, 3'd3, 4'b0110}) begin bad++; $display("FAIL movi_wr32 got=%b exp=%b", b_ctl, {1'b0, 3'b100, 3'd3, 4'b0110}); end
    total++; if (a_sximm8 !== 16'hFFFB) begin bad++; $display("FAIL movi_sximm8 got=%h exp=fffb", a_sximm8); end
    total++; if (b_sximm8 !== 32'hFFFFFFFB) begin bad++; $display("FAIL movi_sximm8_32 got=%h exp=fffffffb", b_sximm8); end
    total++; if (a_fld !== {3'b110, 2'b10, 2'b10, 2'b11}) begin bad++; $display("FAIL movi_fields got=%b exp=%b", a_fld, {3'b110, 2'b10, 2'b10, 2'b11}); end
    step();
    @(negedge clk);
    total++; if (a_ctl !== IDLE_CTL) begin bad++; $display("FAIL movi_idle got=%b exp=%b", a_ctl, IDLE_CTL); end
    step();
  endtask

  task automatic test_add();
    offer(16'hA148);
    @(negedge clk);
    total++; if (a_ctl !== {1'b0, 3'b100, 3'd1, 4'b1000}) begin bad++; $display("FAIL add_rda got=%b exp=%b", a_ctl, {1'b0, 3'b100, 3'd1, 4'b1000}); end
    total++; if (a_shift !== 2'b01) begin bad++; $display("FAIL add_shift got=%b exp=01", a_shift); end
    step();
    @(negedge clk);
    total++; if (a_ctl !== {1'b0, 3'b001, 3'd0, 4'b1000}) begin bad++; $display("FAIL add_rdb got=%b exp=%b", a_ctl, {1'b0, 3'b001, 3'd0, 4'b1000}); end
    step();
    @(negedge clk);
    total++; if (a_ctl !== {1'b1, 3'b010, 3'd2, 4'b0110}) begin bad++; $display("FAIL add_wr16 got=%b exp=%b", a_ctl, {1'b1, 3'b010, 3'd2, 4'b0110}); end
    total++; if (b_ctl !== {1'b0, 3'b010, 3'd2, 4'b0110}) begin bad++; $display("FAIL add_wr32 got=%b exp=%b", b_ctl, {1'b0, 3'b010, 3'd2, 4'b0110}); end
    total++; if (b_shift !== 2'b01) begin bad++; $display("FAIL add_shift32 got=%b exp=01", b_shift); end
    step();
    @(negedge clk);
    total++; if (a_ctl !== IDLE_CTL) begin bad++; $display("FAIL add_idle got=%b exp=%b", a_ctl, IDLE_CTL); end
    step();
  endtask

  task automatic test_back_to_back();
    offer(16'hAD06);
    @(negedge clk);
    total++; if (a_ctl !== {1'b0, 3'b100, 3'd5, 4'b1000}) begin bad++; $display("FAIL cmp_rda got=%b exp=%b", a_ctl, {1'b0, 3'b100, 3'd5, 4'b1000}); end
    step();
    @(negedge clk);
    total++; if (a_ctl !== {1'b1, 3'b001, 3'd6, 4'b1010}) begin bad++; $display("FAIL cmp_rdb16 got=%b exp=%b", a_ctl, {1'b1, 3'b001, 3'd6, 4'b1010}); end
    total++; if (b_ctl !== {1'b0, 3'b001, 3'd6, 4'b1010}) begin bad++; $display("FAIL cmp_rdb32 got=%b exp=%b", b_ctl, {1'b0, 3'b001, 3'd6, 4'b1010}); end
    in_valid = 1'b1;
    instr    = 16'hB8E4;
    step();
    in_valid = 1'b0;
    instr    = 16'h5A5A;
    @(negedge clk);
    total++; if (a_ctl !== {1'b0, 3'b001, 3'd4, 4'b1000}) begin bad++; $display("FAIL mvn_rdb got=%b exp=%b", a_ctl, {1'b0, 3'b001, 3'd4, 4'b1000}); end
    total++; if (b_ctl !== IDLE_CTL) begin bad++; $display("FAIL mvn_ignored32 got=%b exp=%b", b_ctl, IDLE_CTL); end
    step();
    @(negedge clk);
    total++; if (a_ctl !== {1'b1, 3'b010, 3'd7, 4'b0110}) begin bad++; $display("FAIL mvn_wr got=%b exp=%b", a_ctl, {1'b1, 3'b010, 3'd7, 4'b0110}); end
    step();
    @(negedge clk);
    total++; if (a_ctl !== IDLE_CTL) begin bad++; $display("FAIL mvn_idle got=%b exp=%b", a_ctl, IDLE_CTL); end
    step();
  endtask

  task automatic test_illegal();
    logic [15:0] words [2];
    words[0] = 16'h0000;
    words[1] = 16'hE000;
    for (int k = 0; k < 2; k++) begin
      offer(words[k]);
      @(negedge clk);
      total++; if (a_ctl !== 11'b0_000_000_0001) begin bad++; $display("FAIL ill_pulse16 w=%h got=%b exp=00000000001", words[k], a_ctl); end
      total++; if (b_ctl !== 11'b0_000_000_0001) begin bad++; $display("FAIL ill_pulse32 w=%h got=%b exp=00000000001", words[k], b_ctl); end
      step();
      @(negedge clk);
      total++; if (a_ctl !== IDLE_CTL) begin bad++; $display("FAIL ill_idle w=%h got=%b exp=%b", words[k], a_ctl, IDLE_CTL); end
      step();
    end
  endtask

  task automatic test_stall();
    offer(16'hA148);
    @(negedge clk);
    total++; if (a_ctl !== {1'b0, 3'b100, 3'd1, 4'b1000}) begin bad++; $display("FAIL stall_rda got=%b exp=%b", a_ctl, {1'b0, 3'b100, 3'd1, 4'b1000}); end
    step();
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (a_ctl !== {1'b0, 3'b001, 3'd0, 4'b1000}) begin bad++; $display("FAIL stall_rdb cyc=%0d got=%b exp=%b", i, a_ctl, {1'b0, 3'b001, 3'd0, 4'b1000}); end
      step();
      if (i == 2) stall = 1'b0;
    end
    stall = 1'b1;
    @(negedge clk);
    total++; if (a_ctl !== {1'b0, 3'b010, 3'd2, 4'b0100}) begin bad++; $display("FAIL stall_wr_held got=%b exp=%b", a_ctl, {1'b0, 3'b010, 3'd2, 4'b0100}); end
    step();
    stall = 1'b0;
    @(negedge clk);
    total++; if (a_ctl !== {1'b1, 3'b010, 3'd2, 4'b0110}) begin bad++; $display("FAIL stall_wr_done got=%b exp=%b", a_ctl, {1'b1, 3'b010, 3'd2, 4'b0110}); end
    step();
    @(negedge clk);
    total++; if (b_ctl !== IDLE_CTL) begin bad++; $display("FAIL stall_idle32 got=%b exp=%b", b_ctl, IDLE_CTL); end
    step();
  endtask

  task automatic test_wide();
    offer(16'hD080);
    @(negedge clk);
    total++; if (b_sximm8 !== 32'hFFFFFF80) begin bad++; $display("FAIL wide_sximm8 got=%h exp=ffffff80", b_sximm8); end
    total++; if (b_sximm5 !== 32'h0) begin bad++; $display("FAIL wide_sximm5 got=%h exp=0", b_sximm5); end
    total++; if (a_sximm8 !== 16'hFF80) begin bad++; $display("FAIL narrow_sximm8 got=%h exp=ff80", a_sximm8); end
    total++; if (b_ctl !== {1'b0, 3'b100, 3'd0, 4'b0110}) begin bad++; $display("FAIL wide_wr got=%b exp=%b", b_ctl, {1'b0, 3'b100, 3'd0, 4'b0110}); end
    step();
  endtask

  task automatic test_reset_mid();
    offer(16'hA148);
    rst_n = 1'b0;
    @(negedge clk);
    total++; if (a_ctl !== {1'b0, 3'b100, 3'd1, 4'b0000}) begin bad++; $display("FAIL rstmid_gate16 got=%b exp=%b", a_ctl, {1'b0, 3'b100, 3'd1, 4'b0000}); end
    total++; if (b_ctl !== {1'b0, 3'b100, 3'd1, 4'b0000}) begin bad++; $display("FAIL rstmid_gate32 got=%b exp=%b", b_ctl, {1'b0, 3'b100, 3'd1, 4'b0000}); end
    step();
    @(negedge clk);
    total++; if (b_ctl !== IDLE_CTL) begin bad++; $display("FAIL rstmid_abort got=%b exp=%b", b_ctl, IDLE_CTL); end
    step();
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (b_ctl !== IDLE_CTL) begin bad++; $display("FAIL rstmid_after_ctl got=%b exp=%b", b_ctl, IDLE_CTL); end
    total++; if ({b_fld, b_sximm5, b_sximm8} !== 73'd0) begin bad++; $display("FAIL rstmid_after_fld got=%h exp=0", {b_fld, b_sximm5, b_sximm8}); end
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      total++; if ({a_write_en, b_write_en} !== 2'b00) begin bad++; $display("FAIL rstmid_nowrite cyc=%0d got=%b exp=00", i, {a_write_en, b_write_en}); end
    end
    step();
  endtask

  initial begin
    test_reset();
    test_mov_imm();
    test_add();
    test_back_to_back();
    test_illegal();
    test_stall();
    test_wide();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
